// File: rtl/param_reg_bank_if.sv
// ---------------------------------------------------------------------------
// param_reg_bank_if
// Register-access strobe bus between the AXI-Lite slave adapter (master side)
// and param_reg_bank (slave side).
//   reg_wr / reg_waddr / reg_wdata : single-cycle write strobe, byte address, data
//   reg_rd / reg_raddr             : single-cycle read strobe, byte address
//   reg_rdata / reg_rvalid         : registered read response, one cycle after reg_rd
// ---------------------------------------------------------------------------
interface param_reg_bank_if #(
    parameter int ADDR_W = 16
);
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_waddr;
    logic [31:0]       reg_wdata;
    logic              reg_rd;
    logic [ADDR_W-1:0] reg_raddr;
    logic [31:0]       reg_rdata;
    logic              reg_rvalid;

    modport master (
        output reg_wr, reg_waddr, reg_wdata, reg_rd, reg_raddr,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_wr, reg_waddr, reg_wdata, reg_rd, reg_raddr,
        output reg_rdata, reg_rvalid
    );
endinterface

// File: rtl/param_reg_bank.sv
// ---------------------------------------------------------------------------
// param_reg_bank
// Control/status register bank for the DMA datapath: ID/DATE/CAPS, CTRL,
// edge-captured maskable W1C interrupt controller, MISC and tx_req command
// pulses, N_SCRATCH scratch registers and N_DBG debug status read ports.
//
// Ports:
//   CLK, RST       : clock, synchronous active-high reset
//   bus (slave)    : reg_wr/reg_waddr/reg_wdata, reg_rd/reg_raddr,
//                    reg_rdata/reg_rvalid (registered, 1-cycle latency)
//   irq_src        : level interrupt sources (synchronous to CLK)
//   dbg_state      : packed debug words, word j at [32j+31:32j]
//   misc_set_flag  : one-cycle pulse after a MISC write
//   misc_set_data  : data of the last MISC write
//   tx_req         : one-cycle pulse after a CTRL write with bit1 set
//   irq_out        : registered level interrupt
//
// Build option: define PARAM_REG_IRQ_HOLDOFF_EN to enable CTRL[31:16] as an
// irq_out holdoff length (irq_out held low H extra cycles after it falls).
// ---------------------------------------------------------------------------
module param_reg_bank #(
    parameter int          ADDR_W    = 16,
    parameter int          N_SCRATCH = 4,
    parameter int          N_DBG     = 2,
    parameter int          N_IRQ     = 8,
    parameter logic [31:0] IP_ID     = 32'hEB9055AA,
    parameter logic [31:0] IP_DATE   = 32'h20190301
) (
    input  logic                 CLK,
    input  logic                 RST,
    param_reg_bank_if.slave      bus,
    input  logic [N_IRQ-1:0]     irq_src,
    input  logic [32*N_DBG-1:0]  dbg_state,
    output logic                 misc_set_flag,
    output logic [31:0]          misc_set_data,
    output logic                 tx_req,
    output logic                 irq_out
);
    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_DATE   = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_CAPS   = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] A_FORCE  = ADDR_W'(32'h18);
    localparam logic [ADDR_W-1:0] A_MISC   = ADDR_W'(32'h1C);

    localparam logic [31:0] CAPS_VAL = {8'(N_IRQ), 8'(N_DBG), 8'(N_SCRATCH), 8'h02};

    logic              ctrl_en_reg;
    logic [N_IRQ-1:0]  mask_reg;
    logic [N_IRQ-1:0]  status_reg;
    logic [N_IRQ-1:0]  status_next;
    logic [N_IRQ-1:0]  src_hist_reg;
    logic [N_IRQ-1:0]  irq_set;
    logic [N_IRQ-1:0]  irq_clr;
    logic              irq_raw;
    logic              irq_out_reg;
    logic              misc_flag_reg;
    logic [31:0]       misc_data_reg;
    logic              tx_req_reg;
    logic [31:0]       rdata_reg;
    logic              rvalid_reg;
    logic [31:0]       rd_word;

    logic [32*N_SCRATCH-1:0] scratch_flat;
    logic [N_SCRATCH-1:0]    scratch_hit;

    logic wr_ctrl, wr_status, wr_mask, wr_force, wr_misc;

    assign wr_ctrl   = bus.reg_wr && (bus.reg_waddr == A_CTRL);
    assign wr_status = bus.reg_wr && (bus.reg_waddr == A_STATUS);
    assign wr_mask   = bus.reg_wr && (bus.reg_waddr == A_MASK);
    assign wr_force  = bus.reg_wr && (bus.reg_waddr == A_FORCE);
    assign wr_misc   = bus.reg_wr && (bus.reg_waddr == A_MISC);

`ifdef PARAM_REG_IRQ_HOLDOFF_EN
    logic [15:0] holdoff_reg;
    logic [15:0] hold_cnt_reg;
`endif

    // Scratch registers: one storage word per entry plus its read-address hit.
    genvar gi;
    generate
        for (gi = 0; gi < N_SCRATCH; gi++) begin : g_scratch
            logic [31:0] word_reg;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    word_reg <= '0;
                end else if (bus.reg_wr && bus.reg_waddr == ADDR_W'(32'h20 + 4 * gi)) begin
                    word_reg <= bus.reg_wdata;
                end
            end
            assign scratch_flat[32*gi +: 32] = word_reg;
            assign scratch_hit[gi] = (bus.reg_raddr == ADDR_W'(32'h20 + 4 * gi));
        end
    endgenerate

    // Interrupt status: edge and force set, W1C clears; set wins on a tie
    // because the OR is applied after the clear.
    always_comb begin
        irq_set     = (irq_src & ~src_hist_reg)
                    | (wr_force  ? bus.reg_wdata[N_IRQ-1:0] : '0);
        irq_clr     = wr_status ? bus.reg_wdata[N_IRQ-1:0] : '0;
        status_next = (status_reg & ~irq_clr) | irq_set;
        irq_raw     = ctrl_en_reg && |(status_reg & mask_reg);
    end

    // Read decode works on current register contents, so a same-cycle write
    // is not visible to the read.
    always_comb begin
        rd_word = '0;
        case (bus.reg_raddr)
            A_ID:     rd_word = IP_ID;
            A_DATE:   rd_word = IP_DATE;
            A_CAPS:   rd_word = CAPS_VAL;
`ifdef PARAM_REG_IRQ_HOLDOFF_EN
            A_CTRL:   rd_word = {holdoff_reg, 15'd0, ctrl_en_reg};
`else
            A_CTRL:   rd_word = {31'd0, ctrl_en_reg};
`endif
            A_STATUS: rd_word = 32'(status_reg);
            A_MASK:   rd_word = 32'(mask_reg);
            A_MISC:   rd_word = misc_data_reg;
            default:  rd_word = '0;
        endcase
        for (int i = 0; i < N_SCRATCH; i++) begin
            if (scratch_hit[i]) rd_word = scratch_flat[32*i +: 32];
        end
        for (int j = 0; j < N_DBG; j++) begin
            if (bus.reg_raddr == ADDR_W'(32'h80 + 32'(4 * j))) rd_word = dbg_state[32*j +: 32];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_en_reg   <= 1'b0;
            mask_reg      <= '0;
            status_reg    <= '0;
            src_hist_reg  <= '0;
            misc_flag_reg <= 1'b0;
            misc_data_reg <= '0;
            tx_req_reg    <= 1'b0;
            rdata_reg     <= '0;
            rvalid_reg    <= 1'b0;
        end else begin
            rvalid_reg    <= bus.reg_rd;
            rdata_reg     <= bus.reg_rd ? rd_word : 32'd0;
            misc_flag_reg <= wr_misc;
            tx_req_reg    <= wr_ctrl && bus.reg_wdata[1];
            status_reg    <= status_next;
            src_hist_reg  <= irq_src;
            if (wr_misc) misc_data_reg <= bus.reg_wdata;
            if (wr_ctrl) ctrl_en_reg   <= bus.reg_wdata[0];
            if (wr_mask) mask_reg      <= bus.reg_wdata[N_IRQ-1:0];
        end
    end

`ifdef PARAM_REG_IRQ_HOLDOFF_EN
    // The counter loads only on a falling irq_out with the counter idle, so a
    // CTRL write during holdoff never restarts the running count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            holdoff_reg  <= '0;
            hold_cnt_reg <= '0;
            irq_out_reg  <= 1'b0;
        end else begin
            if (wr_ctrl) holdoff_reg <= bus.reg_wdata[31:16];
            if (hold_cnt_reg != 16'd0) begin
                irq_out_reg  <= 1'b0;
                hold_cnt_reg <= hold_cnt_reg - 16'd1;
            end else begin
                irq_out_reg <= irq_raw;
                if (irq_out_reg && !irq_raw) hold_cnt_reg <= holdoff_reg;
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_out_reg <= 1'b0;
        end else begin
            irq_out_reg <= irq_raw;
        end
    end
`endif

    assign bus.reg_rdata  = rdata_reg;
    assign bus.reg_rvalid = rvalid_reg;
    assign misc_set_flag  = misc_flag_reg;
    assign misc_set_data  = misc_data_reg;
    assign tx_req         = tx_req_reg;
    assign irq_out        = irq_out_reg;

endmodule

// File: tb/tb_param_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_param_reg_bank
// Directed scenarios followed by randomized register traffic and interrupt
// activity, checked every cycle against a behavioural register-map model.
// ---------------------------------------------------------------------------
module tb_param_reg_bank;
    localparam int AW = 16;
    localparam int NS = 4;
    localparam int ND = 2;
    localparam int NI = 8;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [NI-1:0]       irq_src = '0;
    logic [32*ND-1:0]    dbg_state = '0;
    logic                misc_set_flag;
    logic [31:0]         misc_set_data;
    logic                tx_req;
    logic                irq_out;

    param_reg_bank_if #(.ADDR_W(AW)) bus ();

    param_reg_bank #(
        .ADDR_W(AW), .N_SCRATCH(NS), .N_DBG(ND), .N_IRQ(NI),
        .IP_ID(32'hEB9055AA), .IP_DATE(32'h20190301)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .irq_src(irq_src),
        .dbg_state(dbg_state),
        .misc_set_flag(misc_set_flag),
        .misc_set_data(misc_set_data),
        .tx_req(tx_req),
        .irq_out(irq_out)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // model state
    bit          m_en;
    bit [15:0]   m_hold;
    bit [15:0]   m_cnt;
    bit [NI-1:0] m_mask, m_status, m_prev;
    bit [31:0]   m_scr [NS];
    bit [31:0]   m_misc;
    bit          m_irq;

    // expected outputs after the coming edge (n_) and after the last edge (e_)
    logic [31:0] n_rdata, n_misc_data, e_rdata, e_misc_data;
    logic        n_rvalid, n_flag, n_tx, n_irq;
    logic        e_rvalid, e_flag, e_tx, e_irq;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        int idx;
        case (a)
            16'h0000: return 32'hEB9055AA;
            16'h0004: return 32'h20190301;
            16'h0008: return {8'(NI), 8'(ND), 8'(NS), 8'h02};
`ifdef PARAM_REG_IRQ_HOLDOFF_EN
            16'h000C: return {m_hold, 15'd0, m_en};
`else
            16'h000C: return {31'd0, m_en};
`endif
            16'h0010: return 32'(m_status);
            16'h0014: return 32'(m_mask);
            16'h001C: return m_misc;
            default: ;
        endcase
        if (a[1:0] == 2'b00 && a >= 16'h20 && a < 16'(32'h20 + 4 * NS)) begin
            idx = int'((a - 16'h20) >> 2);
            return m_scr[idx];
        end
        if (a[1:0] == 2'b00 && a >= 16'h80 && a < 16'(32'h80 + 4 * ND)) begin
            idx = int'((a - 16'h80) >> 2);
            return dbg_state[32*idx +: 32];
        end
        return 32'd0;
    endfunction

    // Computes the outputs after the next edge from the inputs now applied,
    // then commits the register-map effects of this cycle.
    task automatic model_step();
        bit          raw;
        bit [NI-1:0] set_b, clr_b;
        int          idx;
        if (RST) begin
            m_en = 0; m_hold = 0; m_cnt = 0; m_mask = 0; m_status = 0; m_prev = 0;
            m_misc = 0; m_irq = 0;
            for (int i = 0; i < NS; i++) m_scr[i] = 0;
            n_rdata = 0; n_rvalid = 0; n_flag = 0; n_tx = 0; n_irq = 0; n_misc_data = 0;
            return;
        end
        n_rvalid = bus.reg_rd;
        n_rdata  = bus.reg_rd ? model_read(bus.reg_raddr) : 32'd0;
        n_flag   = bus.reg_wr && bus.reg_waddr == 16'h1C;
        n_tx     = bus.reg_wr && bus.reg_waddr == 16'h0C && bus.reg_wdata[1];
        raw      = m_en && ((m_status & m_mask) != 0);
`ifdef PARAM_REG_IRQ_HOLDOFF_EN
        if (m_cnt != 0) begin
            n_irq = 0;
            m_cnt = m_cnt - 1;
        end else begin
            n_irq = raw;
            if (m_irq && !raw) m_cnt = m_hold;
        end
`else
        n_irq = raw;
`endif
        m_irq = n_irq;
        set_b = (irq_src & ~m_prev) |
                ((bus.reg_wr && bus.reg_waddr == 16'h18) ? bus.reg_wdata[NI-1:0] : '0);
        clr_b = (bus.reg_wr && bus.reg_waddr == 16'h10) ? bus.reg_wdata[NI-1:0] : '0;
        m_status = (m_status & ~clr_b) | set_b;
        m_prev   = irq_src;
        if (bus.reg_wr) begin
            case (bus.reg_waddr)
                16'h000C: begin
                    m_en = bus.reg_wdata[0];
`ifdef PARAM_REG_IRQ_HOLDOFF_EN
                    m_hold = bus.reg_wdata[31:16];
`endif
                end
                16'h0014: m_mask = bus.reg_wdata[NI-1:0];
                16'h001C: m_misc = bus.reg_wdata;
                default: ;
            endcase
            if (bus.reg_waddr[1:0] == 2'b00 && bus.reg_waddr >= 16'h20 &&
                bus.reg_waddr < 16'(32'h20 + 4 * NS)) begin
                idx = int'((bus.reg_waddr - 16'h20) >> 2);
                m_scr[idx] = bus.reg_wdata;
            end
        end
        n_misc_data = m_misc;
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        e_rdata = n_rdata; e_rvalid = n_rvalid; e_flag = n_flag;
        e_tx = n_tx; e_irq = n_irq; e_misc_data = n_misc_data;
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        bus.reg_wr = 1'b1; bus.reg_waddr = a; bus.reg_wdata = d;
        $display("wr  addr=%04h data=%08h", a, d);
        step();
        bus.reg_wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
        bus.reg_rd = 1'b1; bus.reg_raddr = a;
        step();
        bus.reg_rd = 1'b0;
        $display("rd  addr=%04h data=%08h", a, bus.reg_rdata);
        check(name, bus.reg_rdata, exp);
        check({name, "_rvalid"}, 32'(bus.reg_rvalid), 32'd1);
    endtask

    // Per-cycle comparison against the model, on the inactive clock edge.
    always @(negedge CLK) begin
        if (chk_on) begin
            check("rdata",     bus.reg_rdata,       e_rdata);
            check("rvalid",    32'(bus.reg_rvalid), 32'(e_rvalid));
            check("misc_flag", 32'(misc_set_flag),  32'(e_flag));
            check("misc_data", misc_set_data,       e_misc_data);
            check("tx_req",    32'(tx_req),         32'(e_tx));
            check("irq_out",   32'(irq_out),        32'(e_irq));
        end
    end

    initial begin
        bus.reg_wr = 0; bus.reg_waddr = '0; bus.reg_wdata = '0;
        bus.reg_rd = 0; bus.reg_raddr = '0;
        dbg_state = {32'hCAFEF00D, 32'h0BADBEEF};
        RST = 1'b1;
        step();
        chk_on = 1'b1;
        step(); step();
        RST = 1'b0;
        step();
        check("reset_irq_out", 32'(irq_out), 32'd0);
        check("idle_rdata", bus.reg_rdata, 32'd0);

        // identification
        rd_chk("id", 16'h00, 32'hEB9055AA);
        rd_chk("date", 16'h04, 32'h20190301);
        rd_chk("caps", 16'h08, 32'h08020402);
        step();
        check("idle_rdata2", bus.reg_rdata, 32'd0);
        rd_chk("dbg1", 16'h84, 32'hCAFEF00D);

        // scratch
        wr(16'h20, 32'hDEADBEEF);
        wr(16'h2C, 32'h12345678);
        rd_chk("scr0", 16'h20, 32'hDEADBEEF);
        rd_chk("scr3", 16'h2C, 32'h12345678);
        rd_chk("unmapped30", 16'h30, 32'h0);

        // interrupt edge capture and W1C
        wr(16'h14, 32'h05);
        wr(16'h0C, 32'h01);
        irq_src[0] = 1'b1;
        step();
        check("irq_t1", 32'(irq_out), 32'd0);
        step();
        check("irq_t2", 32'(irq_out), 32'd1);
        rd_chk("status1", 16'h10, 32'h01);
        wr(16'h10, 32'h01);
        step();
        check("irq_cleared", 32'(irq_out), 32'd0);
        repeat (3) step();
        rd_chk("no_retrigger", 16'h10, 32'h00);

        // set wins over same-cycle clear
        irq_src = 8'h05;
        wr(16'h10, 32'h04);
        step();
        check("set_wins_irq", 32'(irq_out), 32'd1);
        rd_chk("set_wins_status", 16'h10, 32'h04);

        // command pulses
        wr(16'h1C, 32'hA5A5A5A5);
        check("misc_pulse", 32'(misc_set_flag), 32'd1);
        check("misc_value", misc_set_data, 32'hA5A5A5A5);
        wr(16'h0C, 32'h02);
        check("tx_pulse", 32'(tx_req), 32'd1);
        check("misc_pulse_end", 32'(misc_set_flag), 32'd0);
        step();
        check("tx_pulse_end", 32'(tx_req), 32'd0);
        rd_chk("ctrl_rb", 16'h0C, 32'h0);
        rd_chk("misc_rb", 16'h1C, 32'hA5A5A5A5);

`ifdef PARAM_REG_IRQ_HOLDOFF_EN
        wr(16'h14, 32'h01);
        wr(16'h0C, 32'h00030001);
        wr(16'h18, 32'h01);
        repeat (3) step();
        wr(16'h10, 32'hFF);
        wr(16'h18, 32'h01);
        repeat (8) step();
`endif

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            int k;
            k = $urandom_range(0, 9);
            bus.reg_wr = ($urandom_range(0, 1) == 1);
            bus.reg_waddr = (k < 7) ? AW'(4 * $urandom_range(0, 63)) :
                            (k == 7) ? AW'(($urandom_range(0, 1) == 1) ? 32'h1C : 32'h0C) :
                            (k == 8) ? AW'(4 * $urandom_range(0, 63) + $urandom_range(1, 3)) :
                                       AW'(32'h1000 + 4 * $urandom_range(0, 63));
            bus.reg_wdata = $urandom;
            if ($urandom_range(0, 3) == 0) bus.reg_wdata[31:16] = 16'(($urandom_range(0, 4)));
            k = $urandom_range(0, 9);
            bus.reg_rd = ($urandom_range(0, 1) == 1);
            bus.reg_raddr = (k < 8) ? AW'(4 * $urandom_range(0, 63)) :
                            (k == 8) ? AW'(4 * $urandom_range(0, 63) + $urandom_range(1, 3)) :
                                       AW'(32'h1000 + 4 * $urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) irq_src = NI'($urandom);
            if ($urandom_range(0, 15) == 0) dbg_state = {$urandom, $urandom};
            $display("rnd cyc=%0d wr=%0b wa=%04h wd=%08h rd=%0b ra=%04h src=%02h",
                     c, bus.reg_wr, bus.reg_waddr, bus.reg_wdata, bus.reg_rd, bus.reg_raddr, irq_src);
            step();
        end
        bus.reg_wr = 0; bus.reg_rd = 0;

        // reset while busy
        wr(16'h14, 32'hFF);
        wr(16'h0C, 32'h00020001);
        wr(16'h18, 32'hFF);
        wr(16'h10, 32'hFF);
        step();
        RST = 1'b1;
        bus.reg_wr = 1'b1; bus.reg_waddr = 16'h1C; bus.reg_wdata = 32'h11111111;
        bus.reg_rd = 1'b1; bus.reg_raddr = 16'h00;
        step();
        bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;
        check("rst_irq", 32'(irq_out), 32'd0);
        check("rst_flag", 32'(misc_set_flag), 32'd0);
        check("rst_misc_data", misc_set_data, 32'd0);
        check("rst_rdata", bus.reg_rdata, 32'd0);
        check("rst_rvalid", 32'(bus.reg_rvalid), 32'd0);
        RST = 1'b0;
        irq_src = '0;
        step();
        rd_chk("rst_scr0", 16'h20, 32'h0);
        rd_chk("rst_mask", 16'h14, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
